// File: rtl/jtpinpon_vram_arb.sv
// Time-division arbiter sharing one synchronous VRAM among the Z80, tilemap scanner and object scanner.
// Optional macro JTPINPON_ARB_STEAL_EN: idle video slots are handed to a pending CPU request.
module jtpinpon_vram_arb #(
    parameter int AW = 12,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cen,
    input  logic          cpu_cs,
    input  logic          cpu_wr,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_din,
    output logic [DW-1:0] cpu_dout,
    output logic          cpu_wait,
    input  logic          scr_req,
    input  logic [AW-1:0] scr_addr,
    output logic [DW-1:0] scr_dout,
    output logic          scr_ok,
    input  logic          obj_req,
    input  logic [AW-1:0] obj_addr,
    output logic [DW-1:0] obj_dout,
    output logic          obj_ok,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
    typedef enum logic [1:0] {OWN_SCR, OWN_CPU, OWN_OBJ} owner_t;

    state_t     state, next_state;
    owner_t     owner, slot_owner, grant_owner;
    logic [1:0] slot;
    logic       cpu_done, cpu_pend, grant, wr_lat, ram_we_q;
    logic       load_addr, capture;

    assign cpu_pend = cpu_cs & ~cpu_done;
    assign cpu_wait = cpu_pend & ~rst;
    // A write already on the bus must not reach the RAM on the edge that resets us.
    assign ram_we   = ram_we_q & ~rst;

    always_comb begin
        if (slot[0])      slot_owner = OWN_CPU;
        else if (slot[1]) slot_owner = OWN_OBJ;
        else              slot_owner = OWN_SCR;
    end

    always_comb begin
        grant_owner = slot_owner;
        case (slot_owner)
            OWN_SCR: grant = scr_req;
            OWN_OBJ: grant = obj_req;
            default: grant = cpu_pend;
        endcase
`ifdef JTPINPON_ARB_STEAL_EN
        if (!grant && cpu_pend) begin
            grant       = 1'b1;
            grant_owner = OWN_CPU;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) slot <= 2'd0;
        else if (cen) slot <= slot + 2'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (cen && grant) next_state = ADDR;
            ADDR:    next_state = DATA;
            DATA:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        load_addr = (state == IDLE) && cen && grant;
        capture   = (state == DATA);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner    <= OWN_SCR;
            wr_lat   <= 1'b0;
            ram_addr <= '0;
            ram_din  <= '0;
            ram_we_q <= 1'b0;
            scr_ok   <= 1'b0;
            obj_ok   <= 1'b0;
            scr_dout <= '0;
            obj_dout <= '0;
            cpu_dout <= '0;
            cpu_done <= 1'b0;
        end else begin
            ram_we_q <= 1'b0;
            scr_ok   <= 1'b0;
            obj_ok   <= 1'b0;
            if (load_addr) begin
                owner    <= grant_owner;
                wr_lat   <= cpu_wr;
                ram_din  <= cpu_din;
                ram_we_q <= (grant_owner == OWN_CPU) && cpu_wr;
                case (grant_owner)
                    OWN_SCR: ram_addr <= scr_addr;
                    OWN_OBJ: ram_addr <= obj_addr;
                    default: ram_addr <= cpu_addr;
                endcase
            end
            // cpu_done holds off cpu_wait until the CPU releases its chip select.
            if (capture) begin
                case (owner)
                    OWN_SCR: begin
                        scr_dout <= ram_dout;
                        scr_ok   <= 1'b1;
                    end
                    OWN_OBJ: begin
                        obj_dout <= ram_dout;
                        obj_ok   <= 1'b1;
                    end
                    default: begin
                        if (!wr_lat) cpu_dout <= ram_dout;
                        cpu_done <= 1'b1;
                    end
                endcase
            end else if (!cpu_cs) begin
                cpu_done <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_jtpinpon_vram_arb.sv
// Self-checking bench for jtpinpon_vram_arb: directed slot scenarios plus randomized traffic
// checked against a slot-level reference model of the time-division rules.
module tb_jtpinpon_vram_arb;

    localparam int AW = 12;
    localparam int DW = 8;
`ifdef JTPINPON_ARB_STEAL_EN
    localparam bit STEAL = 1'b1;
`else
    localparam bit STEAL = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, cen;
    logic          cpu_cs, cpu_wr, cpu_wait;
    logic [AW-1:0] cpu_addr, scr_addr, obj_addr, ram_addr;
    logic [DW-1:0] cpu_din, cpu_dout, scr_dout, obj_dout, ram_din, ram_dout;
    logic          scr_req, scr_ok, obj_req, obj_ok, ram_we;

    int n_checks = 0;
    int n_fail   = 0;
    int tb_slot;

    logic [DW-1:0] mem     [4096];
    logic [DW-1:0] ref_mem [4096];

    jtpinpon_vram_arb #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst), .cen(cen),
        .cpu_cs(cpu_cs), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_dout(cpu_dout), .cpu_wait(cpu_wait),
        .scr_req(scr_req), .scr_addr(scr_addr), .scr_dout(scr_dout), .scr_ok(scr_ok),
        .obj_req(obj_req), .obj_addr(obj_addr), .obj_dout(obj_dout), .obj_ok(obj_ok),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    // Synchronous single-port RAM seen by the arbiter.
    always @(posedge clk) begin
        ram_dout <= mem[ram_addr];
        if (ram_we) mem[ram_addr] = ram_din;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_cen();
        cen = 1'b1;
        cyc();
        cen = 1'b0;
        tb_slot = (tb_slot + 1) % 4;
    endtask

    task automatic test_reset();
        int we_seen = 0;
        int ok_seen = 0;
        rst = 1'b1; cpu_cs = 1'b1; cpu_wr = 1'b1;
        repeat (3) cyc();
        n_checks++; if (cpu_wait !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_wait: got %b expected 0", cpu_wait); end
        n_checks++; if (ram_we !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_we: got %b expected 0", ram_we); end
        n_checks++; if (ram_addr !== '0 || ram_din !== '0) begin n_fail++; $display("[TB] FAIL reset_bus: got %h/%h expected 0/0", ram_addr, ram_din); end
        n_checks++; if ({scr_ok, obj_ok} !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_ok: got %b expected 00", {scr_ok, obj_ok}); end
        n_checks++; if ({scr_dout, obj_dout, cpu_dout} !== '0) begin n_fail++; $display("[TB] FAIL reset_dout: got %h expected 0", {scr_dout, obj_dout, cpu_dout}); end
        cpu_cs = 1'b0; cpu_wr = 1'b0; rst = 1'b0; tb_slot = 0;
        cyc();
        for (int i = 0; i < 8; i++) begin
            cen = 1'b1;
            for (int j = 0; j < 4; j++) begin
                cyc();
                cen = 1'b0;
                if (ram_we) we_seen++;
                if (scr_ok || obj_ok) ok_seen++;
            end
            tb_slot = (tb_slot + 1) % 4;
        end
        n_checks++; if (we_seen != 0) begin n_fail++; $display("[TB] FAIL idle_we: got %0d expected 0", we_seen); end
        n_checks++; if (ok_seen != 0) begin n_fail++; $display("[TB] FAIL idle_ok: got %0d expected 0", ok_seen); end
    endtask

    // After 8 idle cens the slot has wrapped back to 0, so the scanner is granted at once.
    task automatic test_scr_read();
        mem[12'h123] = 8'h5A; ref_mem[12'h123] = 8'h5A;
        scr_addr = 12'h123; scr_req = 1'b1;
        pulse_cen();
        n_checks++; if (ram_addr !== 12'h123) begin n_fail++; $display("[TB] FAIL scr_addr: got %h expected 123", ram_addr); end
        n_checks++; if (ram_we !== 1'b0) begin n_fail++; $display("[TB] FAIL scr_we: got %b expected 0", ram_we); end
        n_checks++; if (cpu_wait !== 1'b0) begin n_fail++; $display("[TB] FAIL scr_wait: got %b expected 0", cpu_wait); end
        cyc();
        n_checks++; if (scr_ok !== 1'b0) begin n_fail++; $display("[TB] FAIL scr_ok_early: got %b expected 0", scr_ok); end
        cyc();
        n_checks++; if (scr_ok !== 1'b1) begin n_fail++; $display("[TB] FAIL scr_ok: got %b expected 1", scr_ok); end
        n_checks++; if (scr_dout !== 8'h5A) begin n_fail++; $display("[TB] FAIL scr_dout: got %h expected 5a", scr_dout); end
        scr_req = 1'b0;
        cyc();
        n_checks++; if (scr_ok !== 1'b0) begin n_fail++; $display("[TB] FAIL scr_ok_width: got %b expected 0", scr_ok); end
        cyc();
    endtask

    task automatic test_cpu_write();
        pulse_cen();
        cyc();
        cpu_cs = 1'b1; cpu_wr = 1'b1; cpu_addr = 12'h040; cpu_din = 8'h3C;
        cyc();
        n_checks++; if (cpu_wait !== 1'b1) begin n_fail++; $display("[TB] FAIL wr_wait_raise: got %b expected 1", cpu_wait); end
        cyc();
        pulse_cen();
        n_checks++; if (cpu_wait !== 1'b1 || ram_we !== 1'b0) begin n_fail++; $display("[TB] FAIL wr_obj_slot: got wait=%b we=%b expected 1/0", cpu_wait, ram_we); end
        cyc(); cyc();
        pulse_cen();
        n_checks++; if (ram_we !== 1'b1) begin n_fail++; $display("[TB] FAIL wr_we: got %b expected 1", ram_we); end
        n_checks++; if (ram_addr !== 12'h040 || ram_din !== 8'h3C) begin n_fail++; $display("[TB] FAIL wr_bus: got %h/%h expected 040/3c", ram_addr, ram_din); end
        cyc();
        n_checks++; if (ram_we !== 1'b0 || cpu_wait !== 1'b1) begin n_fail++; $display("[TB] FAIL wr_data: got we=%b wait=%b expected 0/1", ram_we, cpu_wait); end
        cyc();
        n_checks++; if (cpu_wait !== 1'b0) begin n_fail++; $display("[TB] FAIL wr_release: got %b expected 0", cpu_wait); end
        ref_mem[12'h040] = 8'h3C;
        cpu_cs = 1'b0; cpu_wr = 1'b0;
        cyc(); cyc();
    endtask

    task automatic test_all_three();
        logic [AW-1:0] exp_addr [4];
        int scr_cnt = 0;
        int obj_cnt = 0;
        int we_cnt  = 0;
        exp_addr[0] = 12'h111; exp_addr[1] = 12'h333; exp_addr[2] = 12'h222; exp_addr[3] = 12'h222;
        scr_req = 1'b1; scr_addr = 12'h111;
        obj_req = 1'b1; obj_addr = 12'h222;
        cpu_cs = 1'b1; cpu_wr = 1'b0; cpu_addr = 12'h333;
        for (int i = 0; i < 4; i++) begin
            cen = 1'b1;
            for (int j = 1; j <= 4; j++) begin
                cyc();
                cen = 1'b0;
                if (j == 1) begin
                    n_checks++;
                    if (ram_addr !== exp_addr[i]) begin n_fail++; $display("[TB] FAIL order_%0d: got %h expected %h", i, ram_addr, exp_addr[i]); end
                end
                if (scr_ok) scr_cnt++;
                if (obj_ok) obj_cnt++;
                if (ram_we) we_cnt++;
            end
            tb_slot = (tb_slot + 1) % 4;
        end
        n_checks++; if (scr_cnt != 1 || obj_cnt != 1) begin n_fail++; $display("[TB] FAIL ok_count: got scr=%0d obj=%0d expected 1/1", scr_cnt, obj_cnt); end
        n_checks++; if (we_cnt != 0) begin n_fail++; $display("[TB] FAIL all_we: got %0d expected 0", we_cnt); end
        n_checks++; if (cpu_dout !== ref_mem[12'h333]) begin n_fail++; $display("[TB] FAIL all_cpu_dout: got %h expected %h", cpu_dout, ref_mem[12'h333]); end
        n_checks++; if (scr_dout !== ref_mem[12'h111] || obj_dout !== ref_mem[12'h222]) begin n_fail++; $display("[TB] FAIL all_douts: got %h/%h expected %h/%h", scr_dout, obj_dout, ref_mem[12'h111], ref_mem[12'h222]); end
        n_checks++; if (cpu_wait !== 1'b0) begin n_fail++; $display("[TB] FAIL all_wait: got %b expected 0", cpu_wait); end
        scr_req = 1'b0; obj_req = 1'b0; cpu_cs = 1'b0;
        cyc(); cyc();
    endtask

    task automatic test_steal();
        int got = -1;
        int exp_slot = STEAL ? 0 : 1;
        cpu_cs = 1'b1; cpu_wr = 1'b0; cpu_addr = 12'h0AB;
        for (int c = 0; c < 2; c++) begin
            cen = 1'b1;
            for (int j = 1; j <= 4; j++) begin
                cyc();
                cen = 1'b0;
                if (j == 3 && got < 0 && cpu_wait === 1'b0) got = c;
            end
            tb_slot = (tb_slot + 1) % 4;
        end
        n_checks++; if (got != exp_slot) begin n_fail++; $display("[TB] FAIL steal_slot: got %0d expected %0d", got, exp_slot); end
        n_checks++; if (cpu_dout !== ref_mem[12'h0AB]) begin n_fail++; $display("[TB] FAIL steal_dout: got %h expected %h", cpu_dout, ref_mem[12'h0AB]); end
        cpu_cs = 1'b0;
        cyc(); cyc();
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] old;
        int ok_seen = 0;
        old = mem[12'h0F0];
        pulse_cen();
        cyc(); cyc();
        cpu_cs = 1'b1; cpu_wr = 1'b1; cpu_addr = 12'h0F0; cpu_din = ~old;
        pulse_cen();
        rst = 1'b1;
        #1;
        n_checks++; if (ram_we !== 1'b0 || cpu_wait !== 1'b0) begin n_fail++; $display("[TB] FAIL rstmid_comb: got we=%b wait=%b expected 0/0", ram_we, cpu_wait); end
        cyc();
        n_checks++; if ({scr_dout, obj_dout, cpu_dout} !== '0 || cpu_wait !== 1'b0) begin n_fail++; $display("[TB] FAIL rstmid_state: got %h wait=%b expected 0/0", {scr_dout, obj_dout, cpu_dout}, cpu_wait); end
        rst = 1'b0; cpu_cs = 1'b0; cpu_wr = 1'b0; tb_slot = 0;
        repeat (3) begin
            cyc();
            if (scr_ok || obj_ok || ram_we) ok_seen++;
        end
        n_checks++; if (ok_seen != 0) begin n_fail++; $display("[TB] FAIL rstmid_quiet: got %0d expected 0", ok_seen); end
        n_checks++; if (mem[12'h0F0] !== old) begin n_fail++; $display("[TB] FAIL rstmid_mem: got %h expected %h", mem[12'h0F0], old); end
        scr_req = 1'b1; scr_addr = 12'h7E5;
        pulse_cen();
        n_checks++; if (ram_addr !== 12'h7E5) begin n_fail++; $display("[TB] FAIL rstmid_regrant: got %h expected 7e5", ram_addr); end
        cyc(); cyc();
        n_checks++; if (scr_ok !== 1'b1 || scr_dout !== ref_mem[12'h7E5]) begin n_fail++; $display("[TB] FAIL rstmid_scr: got %b/%h expected 1/%h", scr_ok, scr_dout, ref_mem[12'h7E5]); end
        scr_req = 1'b0;
        cyc();
    endtask

    // Model: each cen offers the slot to its owner (0 scr, 1/3 cpu, 2 obj); a granted access
    // puts its address on the bus next clk and completes two clk later.
    task automatic test_random();
        int owner, gap;
        bit grant, cs_prev, m_done;
        logic [AW-1:0] g_addr;
        logic [DW-1:0] g_din, g_data;
        bit g_wr;
        m_done = 1'b0;
        for (int n = 0; n < 300; n++) begin
            if (!scr_req && $urandom_range(1, 0) == 1) begin scr_req = 1'b1; scr_addr = AW'($urandom); end
            if (!obj_req && $urandom_range(1, 0) == 1) begin obj_req = 1'b1; obj_addr = AW'($urandom); end
            if (!cpu_cs && !m_done && $urandom_range(2, 0) != 0) begin
                cpu_cs = 1'b1; cpu_wr = $urandom_range(1, 0) == 1; cpu_addr = AW'($urandom); cpu_din = DW'($urandom);
            end
            owner = (tb_slot == 0) ? 0 : (tb_slot == 2) ? 2 : 1;
            grant = (owner == 0) ? scr_req : (owner == 2) ? obj_req : (cpu_cs && !m_done);
            if (STEAL && !grant && cpu_cs && !m_done) begin grant = 1'b1; owner = 1; end
            g_addr = (owner == 0) ? scr_addr : (owner == 2) ? obj_addr : cpu_addr;
            g_wr   = (owner == 1) && cpu_wr;
            g_din  = cpu_din;
            g_data = ref_mem[g_addr];
            gap    = $urandom_range(6, 3);
            cen    = 1'b1;
            for (int j = 1; j <= gap; j++) begin
                cs_prev = cpu_cs;
                cyc();
                cen = 1'b0;
                if (j == 3 && grant && owner == 1) m_done = 1'b1;
                else if (!cs_prev) m_done = 1'b0;
                n_checks++;
                if (cpu_wait !== (cpu_cs && !m_done)) begin n_fail++; $display("[TB] FAIL rnd_wait n=%0d j=%0d: got %b expected %b", n, j, cpu_wait, cpu_cs && !m_done); end
                n_checks++;
                if (ram_we !== (j == 1 && grant && g_wr)) begin n_fail++; $display("[TB] FAIL rnd_we n=%0d j=%0d: got %b expected %b", n, j, ram_we, j == 1 && grant && g_wr); end
                if (j == 1 && grant) begin
                    n_checks++;
                    if (ram_addr !== g_addr) begin n_fail++; $display("[TB] FAIL rnd_addr n=%0d: got %h expected %h", n, ram_addr, g_addr); end
                    if (g_wr) begin
                        n_checks++;
                        if (ram_din !== g_din) begin n_fail++; $display("[TB] FAIL rnd_din n=%0d: got %h expected %h", n, ram_din, g_din); end
                    end
                end
                n_checks++;
                if (scr_ok !== (j == 3 && grant && owner == 0) || obj_ok !== (j == 3 && grant && owner == 2)) begin
                    n_fail++; $display("[TB] FAIL rnd_ok n=%0d j=%0d: got scr=%b obj=%b owner=%0d grant=%b", n, j, scr_ok, obj_ok, owner, grant);
                end
                if (j == 3 && grant) begin
                    n_checks++;
                    case (owner)
                        0: begin
                            if (scr_dout !== g_data) begin n_fail++; $display("[TB] FAIL rnd_scr_dout n=%0d: got %h expected %h", n, scr_dout, g_data); end
                            scr_req = 1'b0;
                        end
                        2: begin
                            if (obj_dout !== g_data) begin n_fail++; $display("[TB] FAIL rnd_obj_dout n=%0d: got %h expected %h", n, obj_dout, g_data); end
                            obj_req = 1'b0;
                        end
                        default: begin
                            if (g_wr) ref_mem[g_addr] = g_din;
                            else if (cpu_dout !== g_data) begin n_fail++; $display("[TB] FAIL rnd_cpu_dout n=%0d: got %h expected %h", n, cpu_dout, g_data); end
                            cpu_cs = 1'b0;
                        end
                    endcase
                end
            end
            tb_slot = (tb_slot + 1) % 4;
        end
    endtask

    initial begin
        rst = 1'b1; cen = 1'b0;
        cpu_cs = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_din = '0;
        scr_req = 1'b0; scr_addr = '0; obj_req = 1'b0; obj_addr = '0;
        tb_slot = 0;
        for (int i = 0; i < 4096; i++) begin
            mem[i]     = DW'($urandom);
            ref_mem[i] = mem[i];
        end
        test_reset();
        test_scr_read();
        test_cpu_write();
        test_all_three();
        test_steal();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
